// File: rtl/rsa_stream_ctrl.sv
// Avalon-MM master bridging the RS232 UART to a modular-exponentiation core:
// loads n/d once, then streams ciphertext blocks through the core and returns results.
module rsa_stream_ctrl #(
  parameter int WIDTH       = 256,
  parameter int ADDR_W      = 5,
  parameter int RX_BASE     = 0,
  parameter int TX_BASE     = 4,
  parameter int STATUS_BASE = 8,
  parameter int RX_OK_BIT   = 7,
  parameter int TX_OK_BIT   = 6,
  parameter int OUT_BYTES   = WIDTH/8-1
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              core_start,
  output logic [WIDTH-1:0]  core_a,
  output logic [WIDTH-1:0]  core_d,
  output logic [WIDTH-1:0]  core_n,
  input  logic [WIDTH-1:0]  core_result,
  input  logic              core_finished,
  input  logic              key_reload,
  output logic              key_loaded,
  output logic [15:0]       blocks_done
);

  localparam int BYTES = WIDTH/8;
  localparam int CNT_W = $clog2(2*BYTES+1);

  typedef enum logic [2:0] {Q_RX, RD, START, CALC, Q_TX, WR} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  n_q, n_d, d_q, d_d, a_q, a_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_loaded_q, key_loaded_d;
  logic              reload_q, reload_d;
  logic [15:0]       blocks_done_q, blocks_done_d;

  logic              reload_now;
  logic              key_eff;
  logic [7:0]        rx_byte;
  logic [CNT_W-1:0]  tx_idx;
  logic [7:0]        tx_byte;
  logic              unused_rd;

  // Only a few status bits and the low byte are meaningful; the rest is ignored.
  assign unused_rd = ^avm_readdata;

  assign core_n      = n_q;
  assign core_d      = d_q;
  assign core_a      = a_q;
  assign key_loaded  = key_loaded_q;
  assign blocks_done = blocks_done_q;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q       <= Q_RX;
      n_q           <= '0;
      d_q           <= '0;
      a_q           <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      key_loaded_q  <= 1'b0;
      reload_q      <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      d_q           <= d_d;
      a_q           <= a_d;
      result_q      <= result_d;
      cnt_q         <= cnt_d;
      key_loaded_q  <= key_loaded_d;
      reload_q      <= reload_d;
      blocks_done_q <= blocks_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    d_d           = d_q;
    a_d           = a_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    blocks_done_d = blocks_done_q;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = ADDR_W'(STATUS_BASE);
    avm_writedata = '0;
    core_start    = 1'b0;

    rx_byte = avm_readdata[7:0];
    tx_idx  = CNT_W'(OUT_BYTES-1) - cnt_q;
    tx_byte = 8'(result_q >> {tx_idx, 3'b000});

    // A reload between blocks drops the key at once; one during key loading is discarded.
    reload_now   = reload_q | key_reload;
    key_eff      = key_loaded_q &
                   ~(reload_now && cnt_q == '0 && (state_q == Q_RX || state_q == RD));
    key_loaded_d = key_eff;
    reload_d     = key_eff ? reload_now : 1'b0;

    case (state_q)
      Q_RX: begin
        avm_read = 1'b1;
        if (!avm_waitrequest && avm_readdata[RX_OK_BIT]) state_d = RD;
      end
      RD: begin
        avm_read    = 1'b1;
        avm_address = ADDR_W'(RX_BASE);
        if (!avm_waitrequest) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = Q_RX;
          if (!key_eff) begin
            if (cnt_q < CNT_W'(BYTES)) n_d = {n_q[WIDTH-9:0], rx_byte};
            else                       d_d = {d_q[WIDTH-9:0], rx_byte};
            if (cnt_q == CNT_W'(2*BYTES-1)) begin
              key_loaded_d = 1'b1;
              cnt_d        = '0;
            end
          end else begin
            a_d = {a_q[WIDTH-9:0], rx_byte};
            if (cnt_q == CNT_W'(BYTES-1)) begin
              cnt_d   = '0;
              state_d = START;
            end
          end
        end
      end
      START: begin
        core_start = 1'b1;
        state_d    = CALC;
      end
      CALC: begin
        if (core_finished) begin
          result_d = core_result;
          state_d  = Q_TX;
        end
      end
      Q_TX: begin
        avm_read = 1'b1;
        if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) state_d = WR;
      end
      WR: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_W'(TX_BASE);
        avm_writedata = {24'd0, tx_byte};
        if (!avm_waitrequest) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = Q_TX;
          if (cnt_q == CNT_W'(OUT_BYTES-1)) begin
            blocks_done_d = blocks_done_q + 16'd1;
            cnt_d         = '0;
            state_d       = Q_RX;
            if (reload_now) begin
              key_loaded_d = 1'b0;
              reload_d     = 1'b0;
            end
          end
        end
      end
      default: state_d = Q_RX;
    endcase
  end

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Directed bench for rsa_stream_ctrl (WIDTH=32, OUT_BYTES=3) with a UART slave model
// and a fixed-latency core model.
module tb_rsa_stream_ctrl;

  logic        avm_clk;
  logic        avm_rst;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        core_start;
  logic [31:0] core_a, core_d, core_n, core_result;
  logic        core_finished;
  logic        key_reload;
  logic        key_loaded;
  logic [15:0] blocks_done;

  int          vectors = 0;
  int          miscompares = 0;

  logic [7:0]  rx_src[$];
  int          rx_ptr = 0;
  logic [31:0] txq[$];
  int          hold = 0;
  int          gap = 0;
  bit          stall = 0;
  int          stab_err = 0;
  int          starts = 0;
  int          busy = 0;
  logic [31:0] core_ret = 32'h0;
  logic        model_fin = 1'b0;
  logic        spur_fin = 1'b0;

  bit          pend = 0;
  logic        s_rd, s_wr, rx_ok;
  logic [4:0]  s_addr;
  logic [31:0] s_wd;

  assign core_finished = model_fin | spur_fin;
  assign core_result   = core_ret;

  rsa_stream_ctrl #(.WIDTH(32), .OUT_BYTES(3)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .core_start(core_start), .core_a(core_a), .core_d(core_d), .core_n(core_n),
    .core_result(core_result), .core_finished(core_finished),
    .key_reload(key_reload), .key_loaded(key_loaded), .blocks_done(blocks_done)
  );

  initial begin
    avm_clk = 1'b0;
    forever #5 avm_clk = ~avm_clk;
  end

  // UART slave: decides waitrequest each cycle and commits the transfer it accepts.
  always @(negedge avm_clk) begin
    if (avm_rst) begin
      pend = 0;
      hold = 0;
      avm_waitrequest = 1'b0;
      avm_readdata = 32'h0;
    end else begin
      if (pend && (avm_read !== s_rd || avm_write !== s_wr ||
                   avm_address !== s_addr || avm_writedata !== s_wd))
        stab_err++;
      if (avm_read || avm_write) begin
        avm_waitrequest = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        if (avm_waitrequest) begin
          avm_readdata = 32'hFFFF_FFEE;
        end else if (avm_write) begin
          if (avm_address == 5'd4) txq.push_back(avm_writedata);
        end else if (avm_address == 5'd8) begin
          rx_ok = (rx_ptr < rx_src.size()) && hold == 0;
          if (rx_ptr < rx_src.size() && hold > 0) hold--;
          avm_readdata = {24'd0, rx_ok, (stall ? 1'($urandom_range(0, 1)) : 1'b1), 6'd0};
        end else if (avm_address == 5'd0) begin
          if (rx_ptr < rx_src.size()) begin
            avm_readdata = {24'd0, rx_src[rx_ptr]};
            rx_ptr++;
          end else begin
            avm_readdata = 32'h0;
          end
          hold = gap;
        end
        pend   = avm_waitrequest;
        s_rd   = avm_read;
        s_wr   = avm_write;
        s_addr = avm_address;
        s_wd   = avm_writedata;
      end else begin
        avm_waitrequest = 1'b0;
        pend = 0;
      end
    end
  end

  // Core model: finishes six cycles after each start pulse.
  always @(negedge avm_clk) begin
    if (avm_rst) begin
      busy = 0;
      model_fin = 1'b0;
    end else begin
      model_fin = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) model_fin = 1'b1;
      end
      if (core_start === 1'b1) begin
        starts++;
        busy = 6;
      end
    end
  end

  task automatic test_reset;
    avm_rst = 1'b1;
    key_reload = 1'b0;
    repeat (3) @(posedge avm_clk);
    #1;
    vectors++; if (avm_read !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_read: got %0b want 1", avm_read); end
    vectors++; if (avm_address !== 5'd8) begin miscompares++; $display("[TB] FAIL reset_addr: got %0d want 8", avm_address); end
    vectors++; if (avm_write !== 1'b0 || core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_strobes: write=%0b start=%0b want 0/0", avm_write, core_start); end
    vectors++; if (avm_writedata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h want 0", avm_writedata); end
    vectors++; if (key_loaded !== 1'b0 || blocks_done !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_status: key=%0b blocks=%0d want 0/0", key_loaded, blocks_done); end
    avm_rst = 1'b0;
    @(posedge avm_clk); #1;
  endtask

  task automatic test_key_load;
    logic [7:0] key[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h03};
    for (int i = 0; i < 8; i++) rx_src.push_back(key[i]);
    for (int i = 0; i < 300 && key_loaded !== 1'b1; i++) @(posedge avm_clk);
    #1;
    vectors++; if (key_loaded !== 1'b1) begin miscompares++; $display("[TB] FAIL key_loaded: got %0b want 1", key_loaded); end
    vectors++; if (core_n !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL key_n: got %h want deadbeef", core_n); end
    vectors++; if (core_d !== 32'h00000003) begin miscompares++; $display("[TB] FAIL key_d: got %h want 00000003", core_d); end
    vectors++; if (rx_ptr != rx_src.size()) begin miscompares++; $display("[TB] FAIL key_rx_consumed: got %0d want %0d", rx_ptr, rx_src.size()); end
  endtask

  task automatic test_first_block;
    logic [31:0] exp[3] = '{32'h22, 32'h33, 32'h44};
    logic [31:0] got;
    int txb = txq.size();
    int sb = starts;
    core_ret = 32'h11223344;
    rx_src.push_back(8'h01); rx_src.push_back(8'h02); rx_src.push_back(8'h03); rx_src.push_back(8'h04);
    for (int i = 0; i < 500 && blocks_done !== 16'd1; i++) @(posedge avm_clk);
    #1;
    vectors++; if (blocks_done !== 16'd1) begin miscompares++; $display("[TB] FAIL blk1_done: got %0d want 1", blocks_done); end
    vectors++; if (core_a !== 32'h01020304) begin miscompares++; $display("[TB] FAIL blk1_a: got %h want 01020304", core_a); end
    vectors++; if (starts - sb != 1) begin miscompares++; $display("[TB] FAIL blk1_starts: got %0d want 1", starts - sb); end
    vectors++; if (txq.size() - txb != 3) begin miscompares++; $display("[TB] FAIL blk1_txcount: got %0d want 3", txq.size() - txb); end
    for (int i = 0; i < 3; i++) begin
      got = (txb + i < txq.size()) ? txq[txb + i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL blk1_tx%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp[3] = '{32'hAA, 32'hBB, 32'hCC};
    logic [31:0] got;
    int txb = txq.size();
    int sb = starts;
    core_ret = 32'h99AABBCC;
    rx_src.push_back(8'h0A); rx_src.push_back(8'h0B); rx_src.push_back(8'h0C); rx_src.push_back(8'h0D);
    for (int i = 0; i < 500 && blocks_done !== 16'd2; i++) @(posedge avm_clk);
    #1;
    vectors++; if (blocks_done !== 16'd2) begin miscompares++; $display("[TB] FAIL blk2_done: got %0d want 2", blocks_done); end
    vectors++; if (core_n !== 32'hDEADBEEF || core_d !== 32'h3) begin miscompares++; $display("[TB] FAIL blk2_key: n=%h d=%h want deadbeef/00000003", core_n, core_d); end
    vectors++; if (core_a !== 32'h0A0B0C0D) begin miscompares++; $display("[TB] FAIL blk2_a: got %h want 0a0b0c0d", core_a); end
    vectors++; if (starts - sb != 1) begin miscompares++; $display("[TB] FAIL blk2_starts: got %0d want 1", starts - sb); end
    for (int i = 0; i < 3; i++) begin
      got = (txb + i < txq.size()) ? txq[txb + i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL blk2_tx%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_stalls;
    logic [31:0] exp[3] = '{32'h22, 32'h33, 32'h44};
    logic [31:0] got;
    int txb = txq.size();
    stall = 1;
    gap = 3;
    core_ret = 32'h11223344;
    rx_src.push_back(8'h01); rx_src.push_back(8'h02); rx_src.push_back(8'h03); rx_src.push_back(8'h04);
    for (int i = 0; i < 3000 && blocks_done !== 16'd3; i++) @(posedge avm_clk);
    #1;
    stall = 0;
    gap = 0;
    vectors++; if (blocks_done !== 16'd3) begin miscompares++; $display("[TB] FAIL stall_done: got %0d want 3", blocks_done); end
    vectors++; if (core_a !== 32'h01020304) begin miscompares++; $display("[TB] FAIL stall_a: got %h want 01020304", core_a); end
    vectors++; if (core_n !== 32'hDEADBEEF || core_d !== 32'h3) begin miscompares++; $display("[TB] FAIL stall_key: n=%h d=%h want deadbeef/00000003", core_n, core_d); end
    vectors++; if (txq.size() - txb != 3) begin miscompares++; $display("[TB] FAIL stall_txcount: got %0d want 3", txq.size() - txb); end
    for (int i = 0; i < 3; i++) begin
      got = (txb + i < txq.size()) ? txq[txb + i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL stall_tx%0d: got %h want %h", i, got, exp[i]); end
    end
    vectors++; if (stab_err != 0) begin miscompares++; $display("[TB] FAIL stall_stability: got %0d changes want 0", stab_err); end
  endtask

  task automatic test_reload;
    logic [31:0] exp[3] = '{32'hBB, 32'hCC, 32'hDD};
    logic [31:0] got;
    logic [7:0] key[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01, 8'h00, 8'h01};
    int txb = txq.size();
    int sb = starts;
    core_ret = 32'hAABBCCDD;
    rx_src.push_back(8'h05); rx_src.push_back(8'h06); rx_src.push_back(8'h07); rx_src.push_back(8'h08);
    for (int i = 0; i < 300 && starts == sb; i++) @(posedge avm_clk);
    #1 key_reload = 1'b1;
    @(posedge avm_clk);
    #1 key_reload = 1'b0;
    for (int i = 0; i < 500 && blocks_done !== 16'd4; i++) @(posedge avm_clk);
    #1;
    vectors++; if (blocks_done !== 16'd4) begin miscompares++; $display("[TB] FAIL reload_done: got %0d want 4", blocks_done); end
    for (int i = 0; i < 3; i++) begin
      got = (txb + i < txq.size()) ? txq[txb + i] : 32'hxxxxxxxx;
      vectors++; if (got !== exp[i]) begin miscompares++; $display("[TB] FAIL reload_tx%0d: got %h want %h", i, got, exp[i]); end
    end
    vectors++; if (key_loaded !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_dropped: got %0b want 0", key_loaded); end
    for (int i = 0; i < 7; i++) rx_src.push_back(key[i]);
    repeat (60) @(posedge avm_clk);
    #1;
    vectors++; if (key_loaded !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_partial: got %0b want 0", key_loaded); end
    vectors++; if (core_a !== 32'h05060708) begin miscompares++; $display("[TB] FAIL reload_a_kept: got %h want 05060708", core_a); end
    rx_src.push_back(key[7]);
    for (int i = 0; i < 100 && key_loaded !== 1'b1; i++) @(posedge avm_clk);
    #1;
    vectors++; if (key_loaded !== 1'b1) begin miscompares++; $display("[TB] FAIL reload_loaded: got %0b want 1", key_loaded); end
    vectors++; if (core_n !== 32'h12345678 || core_d !== 32'h00010001) begin miscompares++; $display("[TB] FAIL reload_key: n=%h d=%h want 12345678/00010001", core_n, core_d); end
  endtask

  task automatic test_spurious;
    int txb = txq.size();
    @(posedge avm_clk);
    #1 spur_fin = 1'b1;
    @(posedge avm_clk);
    #1 spur_fin = 1'b0;
    repeat (20) @(posedge avm_clk);
    #1;
    vectors++; if (txq.size() != txb) begin miscompares++; $display("[TB] FAIL spurious_tx: got %0d writes want 0", txq.size() - txb); end
    vectors++; if (blocks_done !== 16'd4) begin miscompares++; $display("[TB] FAIL spurious_done: got %0d want 4", blocks_done); end
  endtask

  task automatic test_reset_mid_wr;
    core_ret = 32'h00C0FFEE;
    rx_src.push_back(8'h01); rx_src.push_back(8'h02); rx_src.push_back(8'h03); rx_src.push_back(8'h04);
    for (int i = 0; i < 300 && avm_write !== 1'b1; i++) begin
      @(posedge avm_clk);
      #1;
    end
    vectors++; if (avm_write !== 1'b1) begin miscompares++; $display("[TB] FAIL midwr_reached: write=%0b want 1", avm_write); end
    avm_rst = 1'b1;
    #1;
    vectors++; if (avm_read !== 1'b1 || avm_write !== 1'b0) begin miscompares++; $display("[TB] FAIL midwr_strobes: read=%0b write=%0b want 1/0", avm_read, avm_write); end
    vectors++; if (avm_address !== 5'd8) begin miscompares++; $display("[TB] FAIL midwr_addr: got %0d want 8", avm_address); end
    vectors++; if (key_loaded !== 1'b0 || blocks_done !== 16'd0) begin miscompares++; $display("[TB] FAIL midwr_status: key=%0b blocks=%0d want 0/0", key_loaded, blocks_done); end
    vectors++; if (core_n !== 32'h0 || core_a !== 32'h0 || avm_writedata !== 32'h0) begin miscompares++; $display("[TB] FAIL midwr_regs: n=%h a=%h wd=%h want 0/0/0", core_n, core_a, avm_writedata); end
    @(posedge avm_clk);
    #1 avm_rst = 1'b0;
  endtask

  initial begin
    $display("[TB] rsa_stream_ctrl bench start");
    test_reset;
    test_key_load;
    test_first_block;
    test_back_to_back;
    test_stalls;
    test_reload;
    test_spurious;
    test_reset_mid_wr;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rsa_stream_ctrl.md
Name: rsa_stream_ctrl

Overview:
- Parametrised Avalon-MM master that connects the RS232 UART IP to an external modular-exponentiation core.
- Loads a key (n, then d) once over the UART, then processes an unbounded stream of ciphertext blocks without reloading the key.
- For each block it starts the core, waits for the result and transmits the result bytes back over the UART.
- Sits between the Qsys UART slave and the core, replacing the single-shot wrapper.

Parameters:
WIDTH, 256, operand width in bits; multiple of 8, range 16..1024
ADDR_W, 5, Avalon address width
RX_BASE, 0, UART RX data register address
TX_BASE, 4, UART TX data register address
STATUS_BASE, 8, UART status register address
RX_OK_BIT, 7, status bit: RX byte available
TX_OK_BIT, 6, status bit: TX ready
OUT_BYTES, WIDTH/8-1, result bytes sent per block, least significant OUT_BYTES bytes

Ports:
avm_clk  in  1  clock
avm_rst  in  1  reset, asynchronous, active-high
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read request
avm_readdata  in  32  Avalon read data, valid in cycle waitrequest=0
avm_write  out  1  Avalon write request
avm_writedata  out  32  Avalon write data
avm_waitrequest  in  1  slave stall
core_start  out  1  one-cycle start pulse to core
core_a  out  WIDTH  ciphertext block
core_d  out  WIDTH  exponent
core_n  out  WIDTH  modulus
core_result  in  WIDTH  core result, valid when core_finished=1
core_finished  in  1  one-cycle done pulse from core
key_reload  in  1  pulse: reload key after current block
key_loaded  out  1  high while a valid key is held
blocks_done  out  16  count of fully transmitted blocks, wraps at 65535->0

Behaviour:
- Reset (async, any cycle, including mid-transfer or mid-calculation):
  - avm_read=1, avm_address=STATUS_BASE, avm_write=0, avm_writedata=0, core_start=0.
  - key_loaded=0, blocks_done=0; n/d/a/result registers cleared, byte counter 0, pending-reload flag 0, state Q_RX.
  - Key is lost.
- Avalon rule: once read or write is asserted, address/data/strobes are held stable until the cycle with waitrequest=0. That cycle completes the transfer. Strobes change only on the following edge. No transfer is ever dropped or duplicated.
- Byte order: MSB first on RX and TX. Byte counter width is clog2(2*WIDTH/8+1).
- States and transitions:
  - Q_RX: continuous read of STATUS_BASE.
    - Completed read with bit RX_OK_BIT=1 -> RD (read RX_BASE).
    - Bit RX_OK_BIT=0 -> stay in Q_RX.
  - RD: on completion, shift readdata[7:0] into the target register and increment the byte counter.
    - Key phase (key_loaded=0): bytes 0..WIDTH/8-1 go to n; the next WIDTH/8 go to d.
    - After the last d byte: key_loaded<=1, counter<=0, return to Q_RX.
    - Block phase: WIDTH/8 bytes go to a. On the last byte, counter<=0 and core_start=1 for exactly one cycle (the cycle after the RD completion), then CALC.
    - Any other byte: return to Q_RX.
  - CALC: avm_read=avm_write=0.
    - On core_finished: capture core_result, go to Q_TX.
    - core_finished outside CALC is ignored.
  - Q_TX: continuous read of STATUS_BASE.
    - Bit TX_OK_BIT=1 -> WR.
  - WR: write TX_BASE with writedata={24'd0, result byte k}, k from OUT_BYTES-1 down to 0.
    - On completion, increment the counter.
    - If more bytes remain -> Q_TX.
    - Else: blocks_done+1, counter<=0, then:
      - pending reload -> key_loaded<=0 and clear the flag, then Q_RX;
      - otherwise -> Q_RX (next block).
- key_reload is latched in any state and takes effect only at block end or immediately if in Q_RX/RD between blocks with counter=0. A reload mid-key-load is ignored.
- core_n/core_d/core_a are driven directly from registers. They are stable from core_start until core_finished.
- Latency per block, zero wait states: 1 core_start cycle plus core time, plus 2 cycles per RX byte and 2 cycles per TX byte when status is immediately ready.

Test Plan:
- WIDTH=32, OUT_BYTES=3, no stalls. RX bytes n=DE AD BE EF, d=00 00 00 03 -> key_loaded=1 after the 8th byte; core_n=DEADBEEF, core_d=00000003.
- Then RX a=01 02 03 04 -> core_a=01020304, one core_start pulse. Core model returns 0x11223344 -> TX writes 0x22, 0x33, 0x44 in order; blocks_done=1.
- Second block 0A0B0C0D with no key resend -> core_n/core_d unchanged, core_a=0A0B0C0D; blocks_done=2.
- Random avm_waitrequest (50%) plus RX_OK low for 3 polls between bytes -> identical registers and TX byte sequence; strobes/address stable during every stall.
- key_reload pulsed during CALC -> current block fully transmitted. The next 8 RX bytes load a new key, and key_loaded=0 until then.
- avm_rst asserted mid-WR -> next cycle read=1, address=8, write=0, key_loaded=0, blocks_done=0. Spurious core_finished in Q_RX -> no TX write.
